// File: rtl/next_pc_unit_pkg.sv
// next_pc_unit_pkg: shared constants for the next-PC unit and its return-address stack.
// Latency: n/a (constants only).
// Backpressure: n/a.
package next_pc_unit_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 32;
  localparam int DEFAULT_RAS_DEPTH   = 8;
  localparam int DEFAULT_RAS_PTR_W   = 3;
  // PC+4 plus this offset skips the delay slot, giving PC+8 as the link.
  localparam int DEFAULT_LINK_OFFSET = 4;

  // MIPS return-address register ($ra).
  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/next_pc_unit_ras.sv
// ras_stack: circular return-address stack with a push/pop/top interface.
// Latency: push/pop take effect at the next edge; top is combinational from the current state.
// Backpressure: stall freezes the pointer, count and entries; push and pop are ignored while stalled.
// Ports: clk/rst_n (async active-low), stall, push + push_data, pop, top (current top entry), count.
module ras_stack
  import next_pc_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_RAS_DEPTH,
  parameter int PTR_W      = DEFAULT_RAS_PTR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] top,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  // ptr is the next write slot; the top of stack sits one below it.
  logic [PTR_W-1:0]      ptr;

  assign top = mem[ptr - PTR_ONE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!stall) begin
      if (push) begin
        // When full, ptr already points at the oldest entry, so the
        // write overwrites it and the count stays saturated.
        mem[ptr] <= push_data;
        ptr      <= ptr + PTR_ONE;
        if (count != CNT_MAX) begin
          count <= count + CNT_ONE;
        end
      end else if (pop && (count != '0)) begin
        ptr   <= ptr - PTR_ONE;
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: jump / jump-register / branch target calculator with a return-address stack.
// Latency: 1 cycle from an accepted decode instruction to Redirect/NextInstructionAddress/RAS flags.
// Backpressure: Stall holds every register and the RAS; Flush squashes the accepting instruction.
// Ports: CLOCK, RESET (async active-low); decode inputs Valid/Stall/Flush, Instr_PC_Plus4, Instruction,
//        control decode Jump/JumpRegister/Link/Branch/BranchTaken, rs value/index RegisterValue/Register;
//        outputs NextInstructionAddress, Redirect, RAS_Hit, RAS_Mispredict (registered), RAS_Count.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int RAS_DEPTH   = DEFAULT_RAS_DEPTH,
  parameter int RAS_PTR_W   = DEFAULT_RAS_PTR_W,
  parameter int LINK_OFFSET = DEFAULT_LINK_OFFSET
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  Valid,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic [ADDR_WIDTH-1:0] Instr_PC_Plus4,
  input  logic [31:0]           Instruction,
  input  logic                  Jump,
  input  logic                  JumpRegister,
  input  logic                  Link,
  input  logic                  Branch,
  input  logic                  BranchTaken,
  input  logic [ADDR_WIDTH-1:0] RegisterValue,
  input  logic [4:0]            Register,
  output logic [ADDR_WIDTH-1:0] NextInstructionAddress,
  output logic                  Redirect,
  output logic                  RAS_Hit,
  output logic                  RAS_Mispredict,
  output logic [RAS_PTR_W:0]    RAS_Count
);

  logic                  accept;
  logic                  ras_pop;
  logic                  ras_push;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic [ADDR_WIDTH-1:0] branch_offset;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] link_addr;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [RAS_PTR_W:0]    ras_count;
  logic                  unused_opcode;

  // The opcode field is decoded upstream; only the immediates are used here.
  assign unused_opcode = ^Instruction[31:26];

  assign accept = Valid & ~Stall & ~Flush;

  // jalr $31 writes $ra rather than returning through it, so it only pushes.
  assign ras_pop  = accept & JumpRegister & (Register == REG_RA) & ~Link;
  assign ras_push = accept & Link & (Jump | JumpRegister);

  // Jump region keeps the PC bits above the 28-bit pseudo-direct field.
  if (ADDR_WIDTH > 28) begin : g_jump_region
    assign jump_target = {Instr_PC_Plus4[ADDR_WIDTH-1:28], Instruction[25:0], 2'b00};
  end else begin : g_jump_flat
    assign jump_target = {Instruction[25:0], 2'b00};
  end

  assign branch_offset = {{(ADDR_WIDTH - 18){Instruction[15]}}, Instruction[15:0], 2'b00};
  assign branch_target = Instr_PC_Plus4 + branch_offset;
  assign link_addr     = Instr_PC_Plus4 + ADDR_WIDTH'(LINK_OFFSET);

  always_comb begin
    target = branch_target;
    if (Jump) begin
      target = jump_target;
    end else if (JumpRegister) begin
      target = RegisterValue;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      NextInstructionAddress <= '0;
      Redirect               <= 1'b0;
      RAS_Hit                <= 1'b0;
      RAS_Mispredict         <= 1'b0;
    end else if (!Stall) begin
      if (accept) begin
        NextInstructionAddress <= target;
        Redirect               <= Jump | JumpRegister | (Branch & BranchTaken);
        // The stack only advises; the redirect always uses the real rs value.
        RAS_Hit                <= ras_pop & (ras_count != '0);
        RAS_Mispredict         <= ras_pop & (ras_count != '0) & (ras_top != RegisterValue);
      end else begin
        // Flushed or empty slot: drop the flags, keep the last address.
        Redirect       <= 1'b0;
        RAS_Hit        <= 1'b0;
        RAS_Mispredict <= 1'b0;
      end
    end
  end

  ras_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (RAS_DEPTH),
    .PTR_W      (RAS_PTR_W)
  ) u_ras (
    .clk       (CLOCK),
    .rst_n     (RESET),
    .stall     (Stall),
    .push      (ras_push),
    .push_data (link_addr),
    .pop       (ras_pop),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign RAS_Count = ras_count;

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed-vector bench with a scoreboard queue and a decoupled monitor.
// Latency: expectations are tagged with the cycle whose edge should produce them.
// Backpressure: exercises Stall/Flush hold behaviour and the asynchronous reset.
module tb_next_pc_unit;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        Valid, Stall, Flush;
  logic [31:0] Instr_PC_Plus4;
  logic [31:0] Instruction;
  logic        Jump, JumpRegister, Link, Branch, BranchTaken;
  logic [31:0] RegisterValue;
  logic [4:0]  Register;
  logic [31:0] NextInstructionAddress;
  logic        Redirect, RAS_Hit, RAS_Mispredict;
  logic [3:0]  RAS_Count;

  always #5 CLOCK = ~CLOCK;

  next_pc_unit #(
    .ADDR_WIDTH  (32),
    .RAS_DEPTH   (8),
    .RAS_PTR_W   (3),
    .LINK_OFFSET (4)
  ) dut (
    .CLOCK                  (CLOCK),
    .RESET                  (RESET),
    .Valid                  (Valid),
    .Stall                  (Stall),
    .Flush                  (Flush),
    .Instr_PC_Plus4         (Instr_PC_Plus4),
    .Instruction            (Instruction),
    .Jump                   (Jump),
    .JumpRegister           (JumpRegister),
    .Link                   (Link),
    .Branch                 (Branch),
    .BranchTaken            (BranchTaken),
    .RegisterValue          (RegisterValue),
    .Register               (Register),
    .NextInstructionAddress (NextInstructionAddress),
    .Redirect               (Redirect),
    .RAS_Hit                (RAS_Hit),
    .RAS_Mispredict         (RAS_Mispredict),
    .RAS_Count              (RAS_Count)
  );

  typedef struct {
    int          tag;
    int          id;
    logic [31:0] nia;
    bit          chk_nia;
    logic        red;
    logic        hit;
    logic        misp;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   sid    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step%0d: got 0x%08h expected 0x%08h", nm, id, act, exp);
  endtask

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Monitor: compares whatever the DUT presents against expectations due this cycle.
  always @(negedge CLOCK) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.tag < cyc) begin
        n_chk++;
        $display("FAIL missed step%0d: due cycle %0d, now %0d", mon_e.id, mon_e.tag, cyc);
      end else begin
        if (mon_e.chk_nia) check("nia", mon_e.id, NextInstructionAddress, mon_e.nia);
        check("redirect", mon_e.id, {31'd0, Redirect}, {31'd0, mon_e.red});
        check("ras_hit", mon_e.id, {31'd0, RAS_Hit}, {31'd0, mon_e.hit});
        check("ras_misp", mon_e.id, {31'd0, RAS_Mispredict}, {31'd0, mon_e.misp});
        check("ras_count", mon_e.id, {28'd0, RAS_Count}, {28'd0, mon_e.cnt});
      end
    end
  end

  // Queue the expected result of the inputs currently driven, then advance one edge.
  task automatic apply(input logic [31:0] nia, input bit chk, input logic red, input logic hit,
                       input logic misp, input logic [3:0] cnt);
    exp_t e;
    e.tag = cyc + 1; e.id = sid; e.nia = nia; e.chk_nia = chk;
    e.red = red; e.hit = hit; e.misp = misp; e.cnt = cnt;
    sid++;
    sb.push_back(e);
    @(posedge CLOCK);
    #1;
  endtask

  task automatic clr();
    Valid = 0; Stall = 0; Flush = 0; Jump = 0; JumpRegister = 0; Link = 0;
    Branch = 0; BranchTaken = 0; Instruction = 0; Register = 0;
    RegisterValue = 0; Instr_PC_Plus4 = 0;
  endtask

  task automatic drv_j(input logic [31:0] pc4, input logic [31:0] ins, input logic lnk);
    clr(); Valid = 1; Jump = 1; Link = lnk; Instr_PC_Plus4 = pc4; Instruction = ins;
  endtask

  task automatic drv_jr31(input logic [31:0] rv);
    clr(); Valid = 1; JumpRegister = 1; Register = 5'd31; RegisterValue = rv;
    Instruction = 32'h03E00008;
  endtask

  task automatic drv_br(input logic [31:0] pc4, input logic [31:0] ins, input logic tk);
    clr(); Valid = 1; Branch = 1; BranchTaken = tk; Instr_PC_Plus4 = pc4; Instruction = ins;
  endtask

  task automatic check_reset_outputs(input int id);
    check("rst_nia", id, NextInstructionAddress, 32'h0);
    check("rst_redirect", id, {31'd0, Redirect}, 32'h0);
    check("rst_hit", id, {31'd0, RAS_Hit}, 32'h0);
    check("rst_misp", id, {31'd0, RAS_Mispredict}, 32'h0);
    check("rst_count", id, {28'd0, RAS_Count}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    clr();
    #2 RESET = 0;
    #1 check_reset_outputs(-1);
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1;

    // j: {0, 0x0100004, 00} = 0x00400010
    drv_j(32'h00400010, 32'h08100004, 0);
    apply(32'h00400010, 1, 1, 0, 0, 0);

    // beq imm=-1: 0x00400020 - 4
    drv_br(32'h00400020, 32'h1000FFFF, 1);
    apply(32'h0040001C, 1, 1, 0, 0, 0);
    drv_br(32'h00400020, 32'h1000FFFF, 0);
    apply(32'h0040001C, 0, 0, 0, 0, 0);

    // jal / jr $31 correct prediction, then mispredict
    drv_j(32'h00400100, 32'h0C100040, 1);
    apply(32'h00400100, 1, 1, 0, 0, 1);
    drv_jr31(32'h00400104);
    apply(32'h00400104, 1, 1, 1, 0, 0);
    drv_j(32'h00400100, 32'h0C100040, 1);
    apply(32'h00400100, 1, 1, 0, 0, 1);
    drv_jr31(32'h00400200);
    apply(32'h00400200, 1, 1, 1, 1, 0);

    // Overflow: 9 jals, link A_i = 0x00401000 + 16*i + 4
    for (int i = 1; i <= 9; i++) begin
      drv_j(32'h00401000 + 32'(16 * i), 32'h0C000000 | 32'(i), 1);
      apply(32'(4 * i), 1, 1, 0, 0, (i < 8) ? 4'(i) : 4'd8);
    end
    for (int k = 1; k <= 8; k++) begin
      a = 32'h00401000 + 32'(16 * (10 - k)) + 32'd4;
      drv_jr31(a);
      apply(a, 1, 1, 1, 0, 4'(8 - k));
    end
    drv_jr31(32'h00402000);
    apply(32'h00402000, 1, 1, 0, 0, 0);

    // Idle slot: flags drop, address held
    clr();
    apply(32'h00402000, 1, 0, 0, 0, 0);
    // Valid non-control instruction: no redirect
    clr(); Valid = 1; Instr_PC_Plus4 = 32'h00402100; Instruction = 32'h00851020;
    apply(32'h0, 0, 0, 0, 0, 0);

    // Stall / Flush
    drv_j(32'h00403000, 32'h0C100C00, 1);
    apply(32'h00403000, 1, 1, 0, 0, 1);
    drv_jr31(32'h00403004);
    apply(32'h00403004, 1, 1, 1, 0, 0);
    drv_j(32'h00403100, 32'h0C100C40, 1); Stall = 1;
    apply(32'h00403004, 1, 1, 1, 0, 0);
    apply(32'h00403004, 1, 1, 1, 0, 0);
    Flush = 1;
    apply(32'h00403004, 1, 1, 1, 0, 0);
    Stall = 0;
    apply(32'h00403004, 1, 0, 0, 0, 0);
    Flush = 0;
    apply(32'h00403100, 1, 1, 0, 0, 1);

    // Reset mid-operation
    for (int i = 1; i <= 3; i++) begin
      drv_j(32'h00404000 + 32'(16 * i), 32'h0C000000 | 32'(i), 1);
      apply(32'(4 * i), 1, 1, 0, 0, 4'(1 + i));
    end
    clr();
    @(negedge CLOCK);
    #2 RESET = 0;
    #1 check_reset_outputs(-2);
    @(posedge CLOCK);
    #1 RESET = 1;
    drv_jr31(32'h00400500);
    apply(32'h00400500, 1, 1, 0, 0, 0);

    // jalr $31: push only, no pop
    drv_jr31(32'h00400700); Link = 1; Instr_PC_Plus4 = 32'h00400600;
    apply(32'h00400700, 1, 1, 0, 0, 1);
    drv_jr31(32'h00400604);
    apply(32'h00400604, 1, 1, 1, 0, 0);

    clr();
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge CLOCK);
    #1;
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
